// File: rtl/stb_pkg.sv
// stb_pkg: shared types for the strobe sampler.
// One-hot FSM encoding plus the error code set reported to firmware.
package stb_pkg;

  localparam int unsigned I_IDLE    = 0;
  localparam int unsigned I_REQ     = 1;
  localparam int unsigned I_WAIT    = 2;
  localparam int unsigned I_SETTLE  = 3;
  localparam int unsigned I_CAPTURE = 4;
  localparam int unsigned I_RELEASE = 5;
  localparam int unsigned I_DONE    = 6;

  typedef enum logic [6:0] {
    S_IDLE    = 7'b0000001,
    S_REQ     = 7'b0000010,
    S_WAIT    = 7'b0000100,
    S_SETTLE  = 7'b0001000,
    S_CAPTURE = 7'b0010000,
    S_RELEASE = 7'b0100000,
    S_DONE    = 7'b1000000
  } stb_sampler_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_NOT_RDY = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ABORT   = 2'd3
  } stb_err_t;

endpackage

// File: rtl/stb_sampler_if.sv
// stb_sampler_if: strobe request/valid handshake with the generator.
// The sampler is master; the strobe generator is slave.
interface stb_sampler_if;

  logic stb_req;
  logic stb_valid;
  logic gen_rdy;

  modport master (
    output stb_req,
    input  stb_valid,
    input  gen_rdy
  );

  modport slave (
    input  stb_req,
    output stb_valid,
    output gen_rdy
  );

endinterface

// File: rtl/sync_ff.sv
// sync_ff: multi-stage flop synchroniser for asynchronous inputs.
// Synchronous active-high reset clears every stage.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) q[i] <= '0;
    end else begin
      q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) q[i] <= q[i-1];
    end
  end

  assign q_o = q[STAGES-1];

endmodule

// File: rtl/stb_sampler.sv
// stb_sampler: requests strobes, waits for each fresh valid, and samples
// the synchronised comparator a fixed settle time later, counting ones.
module stb_sampler
  import stb_pkg::*;
#(
  parameter int CNT_WIDTH     = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int TO_WIDTH      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CNT_WIDTH-1:0] n_samples_i,
  input  logic [TO_WIDTH-1:0]  timeout_i,
  stb_sampler_if.master        gen,
  input  logic                 cmp_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           err_o,
  output logic [CNT_WIDTH-1:0] ones_o,
  output logic [CNT_WIDTH-1:0] total_o
);

  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);

  stb_sampler_state_t   state_q, state_d;
  stb_err_t             err_q, err_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [CNT_WIDTH-1:0] ones_q, ones_d;
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic [TO_WIDTH-1:0]  tlim_q, tlim_d;
  logic [TO_WIDTH-1:0]  to_q, to_d;
  logic [SW-1:0]        set_q, set_d;
  logic                 seen_q, seen_d;
  logic                 req_q, busy_q, done_q;
  logic [0:0]           cmp_s;

  sync_ff #(
    .WIDTH  (1),
    .STAGES (2)
  ) u_cmp_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (cmp_i),
    .q_o   (cmp_s)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    n_d     = n_q;
    ones_d  = ones_q;
    total_d = total_q;
    tlim_d  = tlim_q;
    to_d    = to_q;
    set_d   = set_q;
    seen_d  = seen_q;
    if (abort_i && !state_q[I_IDLE]) begin
      err_d   = ERR_ABORT;
      state_d = S_DONE;
    end else begin
      unique case (1'b1)
        state_q[I_IDLE]: begin
          if (start_i) begin
            n_d     = n_samples_i;
            tlim_d  = timeout_i;
            ones_d  = '0;
            total_d = '0;
            err_d   = ERR_NONE;
            if (!gen.gen_rdy) begin
              err_d   = ERR_NOT_RDY;
              state_d = S_DONE;
            end else if (n_samples_i == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_REQ;
            end
          end
        end
        state_q[I_REQ]: begin
          to_d    = '0;
          seen_d  = 1'b0;
          state_d = S_WAIT;
        end
        state_q[I_WAIT]: begin
          set_d = '0;
          if (!gen.stb_valid) seen_d = 1'b1;
          // only a valid preceded by a low level belongs to this request
          if (gen.stb_valid && seen_q) begin
            state_d = S_SETTLE;
          end else begin
            to_d = to_q + TO_WIDTH'(1);
            if (to_d == tlim_q) begin
              err_d   = ERR_TIMEOUT;
              state_d = S_DONE;
            end
          end
        end
        state_q[I_SETTLE]: begin
          if (set_q == SET_LAST) state_d = S_CAPTURE;
          else set_d = set_q + SW'(1);
        end
        state_q[I_CAPTURE]: begin
          ones_d  = ones_q + CNT_WIDTH'(cmp_s);
          total_d = total_q + CNT_WIDTH'(1);
          state_d = S_RELEASE;
        end
        state_q[I_RELEASE]: begin
          state_d = (total_q == n_q) ? S_DONE : S_REQ;
        end
        state_q[I_DONE]: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
      n_q     <= '0;
      ones_q  <= '0;
      total_q <= '0;
      tlim_q  <= '0;
      to_q    <= '0;
      set_q   <= '0;
      seen_q  <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      n_q     <= n_d;
      ones_q  <= ones_d;
      total_q <= total_d;
      tlim_q  <= tlim_d;
      to_q    <= to_d;
      set_q   <= set_d;
      seen_q  <= seen_d;
      // request level held from REQ through CAPTURE
      req_q   <= state_d inside
                 {S_REQ, S_WAIT, S_SETTLE, S_CAPTURE};
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign gen.stb_req = req_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign ones_o      = ones_q;
  assign total_o     = total_q;

endmodule

// File: doc/stb_sampler.md
# stb_sampler

Requester-side counterpart of the strobe generator in the measure unit. It issues strobe requests over the `stb_req`/`stb_valid` handshake, waits for each requested strobe edge, and samples the synchronised comparator output a fixed settle time later. Over N strobes it counts the ones, giving an equivalent-time threshold probability for the calibration firmware.

## Interface
Parameters:
- `CNT_WIDTH`, 16: width of the sample count and the result counters.
- `SETTLE_CYCLES`, 4: number of clk cycles from strobe valid to comparator capture. Must be ≥1.
- `TO_WIDTH`, 32: width of the timeout counter.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: start pulse. Sampled only in IDLE.
- `abort_i` in 1: abort the current run. Honoured in any non-IDLE state.
- `n_samples_i` in CNT_WIDTH: number of strobes. Latched at start.
- `timeout_i` in TO_WIDTH: maximum wait for `stb_valid_i`, in cycles. Latched at start.
- `gen_rdy_i` in 1: generator ready, i.e. the generator has locked the period.
- `stb_req_o` out 1: strobe request level. The generator acts on its rising edge.
- `stb_valid_i` in 1: the generator has produced the requested strobe edge.
- `cmp_i` in 1: asynchronous comparator output.
- `busy_o` out 1: high while the state is not IDLE.
- `done_o` out 1: one-cycle pulse at the end of a run, whether it succeeds or fails.
- `err_o` out 2: 0 = ok, 1 = generator not ready, 2 = timeout, 3 = aborted. Held until the next accepted start.
- `ones_o` out CNT_WIDTH: number of samples captured as 1.
- `total_o` out CNT_WIDTH: number of samples completed.

## Operation
- `cmp_i` passes through a 2-stage synchroniser to produce `cmp_s`.
- State machine states: IDLE, REQ, WAIT_VALID, SETTLE, CAPTURE, RELEASE, DONE.
- **IDLE**
  - On `start_i`: latch `n_samples_i` and `timeout_i`, clear `ones_o`, `total_o` and `err_o`.
  - If `gen_rdy_i`=0: set `err_o`=1 and go to DONE.
  - Else if `n_samples_i`=0: go to DONE.
  - Else go to REQ.
- **REQ**
  - Drive `stb_req_o`=1.
  - Clear the timeout counter and the `seen_low` flag.
  - Go to WAIT_VALID.
- **WAIT_VALID**
  - Set `seen_low` when `stb_valid_i`=0.
  - When `stb_valid_i`=1 and `seen_low`=1: go to SETTLE. A stale valid left over from the previous strobe is therefore never accepted.
  - Otherwise increment the timeout counter. When it equals the latched timeout, set `err_o`=2 and go to DONE.
- **SETTLE**
  - Count SETTLE_CYCLES cycles, then go to CAPTURE.
- **CAPTURE**
  - `ones_o` += `cmp_s`; `total_o` += 1.
  - Go to RELEASE.
- **RELEASE**
  - Drive `stb_req_o`=0 for exactly one cycle, which guarantees a fresh rising edge on the next request.
  - If `total_o` equals the latched N, go to DONE; else go to REQ.
- **DONE**
  - Pulse `done_o`, drive `stb_req_o`=0, go to IDLE.
- **abort_i** in any non-IDLE state, DONE included, has priority over every other transition: `err_o`=3, `stb_req_o`=0, go to DONE.
- `start_i` outside IDLE is ignored.
- `ones_o` ≤ `total_o` ≤ N, so neither counter can wrap.
- Results hold after DONE until the next accepted start.

## Timing
- **Reset values:** state IDLE, `stb_req_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `ones_o`=0, `total_o`=0, synchroniser flops 0.
- All outputs are registered.
- **Start:** `start_i` at edge k gives `stb_req_o`=1 and `busy_o`=1 from k+1.
- **Capture latency:** the first cycle with a qualifying `stb_valid_i` is v. `total_o` updates after edge v+SETTLE_CYCLES+1. `stb_req_o` is low for the one cycle after that, then high again on the following cycle if more samples remain.
- **Done pulse:**
  - Successful run: `done_o` is high on the cycle after RELEASE. `busy_o` falls together with the end of `done_o`.
  - Timeout: the timeout counter equals `timeout_i` after `timeout_i` WAIT_VALID cycles, and `done_o` follows the cycle after that.
- **Abort:** `abort_i` at edge k gives `stb_req_o`=0 and `done_o`=1 at k+1, and IDLE at k+2.
- **Reset mid-run:** `rst_i` forces all reset values on the next edge, including `stb_req_o`=0. No `done_o` pulse is emitted.

## Structure
- Package `stb_pkg`:
  - `stb_sampler_state_t`, a one-hot enum of the seven states.
  - `stb_err_t`, with values ERR_NONE, ERR_NOT_RDY, ERR_TIMEOUT, ERR_ABORT.
- Sub-module: the existing `sync_ff` (WIDTH=1, STAGES=2) for `cmp_i`.
- All other logic lives in a single module.

## Test plan
- **Normal run:** generator model returns valid 5 cycles after each request edge; `cmp_i` alternates 1,0 per strobe; N=8 -> `done_o` once, `ones_o`=4, `total_o`=8, `err_o`=0, exactly 8 rising edges on `stb_req_o`.
- **Not ready:** start with `gen_rdy_i`=0 -> `done_o` at k+1, `err_o`=1, `stb_req_o` never rises.
- **Timeout and stale valid:** `timeout_i`=20, `stb_valid_i` held high from before start and never dropped -> `err_o`=2, `done_o` after 20 WAIT_VALID cycles, `total_o`=0.
- **Abort and ignored start:** abort during SETTLE of sample 3 with N=10 -> `err_o`=3, `total_o`=2, `stb_req_o` low next cycle; a `start_i` issued mid-run is ignored.
- **Zero samples and settle edge:** N=0 -> immediate `done_o`, counts 0. Separately, SETTLE_CYCLES=4 with `cmp_i` rising exactly at capture-minus-2 -> that sample counted as 1; rising at capture-minus-1 -> counted as 0.
- **Reset mid-run:** `rst_i` asserted in WAIT_VALID -> all outputs at reset values next cycle, no `done_o`.
